// File: rtl/datapath_pkg.sv
// Shared widths, opcode and A-source encodings for the accumulator processor datapath.
package datapath_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_OPC_W  = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_RSVD = 2'b11
  } asel_t;

endpackage

// File: rtl/datapath_ram.sv
// Unified program/data RAM: synchronous read register, read-before-write.
module datapath_ram
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array carries no reset so it maps onto a memory macro.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register samples the pre-write word on a same-address write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/datapath.sv
// Execution datapath: PC, IR, accumulator, unified RAM, add/sub unit and A source mux.
module datapath
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned OPC_W  = DEF_OPC_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic              Halt,
  input  logic [DATA_W-1:0] Input,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OPC_W-1:0]  IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] A_out,
  output logic [ADDR_W-1:0] PC_out
);

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;

  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_a_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_ram_addr = Meminst ? r_ir[ADDR_W-1:0] : r_pc;
  assign w_pc_next  = JMPmux ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
  assign w_alu      = Sub ? (r_a - w_rdata) : (r_a + w_rdata);

  // Program-load port wins over the processor store and ignores Halt/reset.
  assign w_we    = prog_we | (MemWr & ~Halt & ~reset);
  assign w_waddr = prog_we ? prog_addr : w_ram_addr;
  assign w_wdata = prog_we ? prog_data : r_a;

  always_comb begin
    w_a_next = r_a;
    case (asel_t'(Asel))
      ASEL_ALU: w_a_next = w_alu;
      ASEL_IN:  w_a_next = Input;
      ASEL_MEM: w_a_next = w_rdata;
      default:  w_a_next = r_a;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
      r_a  <= '0;
    end else if (!Halt) begin
      if (PCload) r_pc <= w_pc_next;
      if (IRload) r_ir <= w_rdata;
      if (Aload)  r_a  <= w_a_next;
    end
  end

  datapath_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_ram_addr),
    .o_rdata (w_rdata)
  );

  assign IR     = r_ir[DATA_W-1 -: OPC_W];
  assign Aeq0   = (r_a == '0);
  assign Apos   = ~r_a[DATA_W-1] & (r_a != '0);
  assign A_out  = r_a;
  assign PC_out = r_pc;

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath for the 8-bit accumulator processor: PC, IR, accumulator A, 32x8 unified RAM, add/sub unit and the A input mux.
- Consumes the control-unit control signals (IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt).
- Returns the status signals (IR opcode, Aeq0, Apos) the control unit decodes.
- Also exposes a program-load port to fill RAM while the processor is held in reset.

Parameters:
- DATA_W, 8, width of A, RAM words, Input and IR.
- ADDR_W, 5, width of PC and the IR address field; RAM depth = 2**ADDR_W.
- OPC_W, 3, opcode width = IR[DATA_W-1 -: OPC_W].

Ports:
- CLOCK_50  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- IRload  in  1  load IR from RAM read data.
- JMPmux  in  1  PC source: 0 = PC+1, 1 = IR address field.
- PCload  in  1  load PC from the JMPmux-selected source.
- Meminst  in  1  RAM address: 0 = PC, 1 = IR[ADDR_W-1:0].
- MemWr  in  1  write A into RAM at the selected address.
- Asel  in  2  A source: 00 add/sub result, 01 Input, 10 RAM read data, 11 reserved.
- Aload  in  1  load A.
- Sub  in  1  add/sub unit: 0 = A+rdata, 1 = A-rdata.
- Halt  in  1  freeze: block all PC/IR/A/RAM writes.
- Input  in  DATA_W  manual input switches.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- IR  out  OPC_W  opcode field of the instruction register.
- Aeq0  out  1  A == 0.
- Apos  out  1  A[DATA_W-1] == 0 and A != 0, i.e. strictly positive.
- A_out  out  DATA_W  accumulator value.
- PC_out  out  ADDR_W  program counter.

Behaviour:
- Reset, synchronous: PC = 0, IR reg = 0, A = 0, rdata reg = 0.
  - Outputs after reset: IR = 0, Aeq0 = 1, Apos = 0, A_out = 0, PC_out = 0.
  - RAM contents are NOT cleared by reset.
- RAM: synchronous read.
  - rdata <= M[addr] every clock, where addr = Meminst ? IR[ADDR_W-1:0] : PC.
  - Read data is visible to the consumer one cycle after the address is presented.
  - Write: if MemWr && !Halt, M[addr] <= A at the edge. rdata shows the old word (read-before-write).
- Resulting timing against the control-unit FSM:
  - start: address = PC.
  - fetch: IR <= rdata (= M[PC]); PC <= PC+1.
  - decode: address = IR addr.
  - load/add/sub use rdata = M[IR addr].
- PC: if PCload && !Halt, PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1.
  - PC+1 wraps modulo 2**ADDR_W (31 -> 0).
- IR: if IRload && !Halt, IR reg <= rdata. The IR output is IR reg[DATA_W-1 -: OPC_W].
- A: if Aload && !Halt, A loads from Asel:
  - 00: A+rdata or A-rdata per Sub, truncated to DATA_W (two's complement wrap; 0x7F+0x01 = 0x80, 0x00-0x01 = 0xFF).
  - 01: Input.
  - 10: rdata.
  - 11: A unchanged.
- Status outputs Aeq0/Apos are combinational from the A register, so they are valid in the cycle after A changes.
- Simultaneous events: one edge may load IR, PC and A and write RAM together; all take pre-edge values. Example: a store reads the old A.
- Program load: when prog_we = 1, M[prog_addr] <= prog_data.
  - prog_we overrides MemWr and Halt.
  - Permitted in any state; correct operation requires the processor to be held in reset.
  - prog_we does not disturb rdata/PC/A.
- Reset mid-operation: registers clear on the next edge regardless of other inputs; a concurrent MemWr is suppressed while reset = 1, but prog_we is still honoured.

Decomposition:
- Shared package:
  - DATA_W/ADDR_W/OPC_W defaults.
  - Opcode constants: LOAD=000, STORE=001, ADD=010, SUB=011, INPUT=100, JZ=101, JPOS=110, HALT=111.
  - Asel encodings: ASEL_ALU=00, ASEL_IN=01, ASEL_MEM=10.
- One sub-module, datapath_ram: 2**ADDR_W x DATA_W, synchronous read, read-before-write.
  - Two write sources muxed in the parent: prog port has priority.

Test Plan:
- Reset: preload junk into A via Input, assert reset one cycle -> PC_out = 0, A_out = 0, IR = 000, Aeq0 = 1, Apos = 0; RAM word 5 written earlier still reads back.
- Fetch/load: program M[0] = 0x05 (LOAD 5), M[5] = 0x2A; drive start, fetch, decode, load control sequence -> IR = 000, PC_out = 1, A_out = 0x2A, Apos = 1.
- Add/sub wrap: A = 0x7F, M[3] = 0x01, add -> A = 0x80, Apos = 0, Aeq0 = 0; then A = 0x00, sub M[3] -> A = 0xFF.
- Store read-before-write: A = 0x33, M[4] = 0x11, store to 4 with rdata sampled that edge -> rdata = 0x11, next read of M[4] = 0x33.
- Jumps: IR = 0xA9 (JZ 9), A = 0, JMPmux = 1, PCload = Aeq0 -> PC_out = 9; PC = 31 with fetch -> PC_out = 0.
- Halt and input: Asel = 01, Input = 0xC4, Aload = 1 -> A = 0xC4; then Halt = 1 with Aload/PCload/MemWr all high -> no register or RAM change; prog_we during Halt still writes.
